alarm_time_setter: RTL and testbench

ALARM_TIME_SETTER -- requirements
Module: alarm_time_setter

---
 rtl/alarm_time_setter.sv | 112 +++++++++++
 tb/tb_alarm_time_setter.sv | 124 ++++++++++++
 2 files changed

// File: rtl/alarm_time_setter.sv
// alarm_time_setter: 24-hour clock with seconds prescaler and push-button BCD alarm editor.
//   Parameter TICK_DIV : clk cycles per one-second tick (2 .. 2^27-1).
//   Optional macro TIME_SET_EN : when defined, set_sel = 1 redirects edits to the current time.
//   Ports:
//     clk      - system clock, rising edge
//     resetn   - asynchronous active-low reset
//     set_mode - 1 = edits enabled, 0 = run only
//     push_u   - increment selected field (rising edge)
//     push_d   - decrement selected field (rising edge)
//     push_c   - toggle hour/minute field (rising edge, always active)
//     set_sel  - edit target: 0 = alarm, 1 = current time (TIME_SET_EN only)
//     current  - current time BCD {H10,H1,M10,M1}
//     alarm    - alarm time BCD {H10,H1,M10,M1}
//     sec      - current seconds, binary 0..59
//     field_hr - 1 = hour field selected, 0 = minute field
//     tick     - one-cycle pulse while the prescaler sits at its last count
module alarm_time_setter #(
    parameter int TICK_DIV = 100000000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        set_mode,
    input  logic        push_u,
    input  logic        push_d,
    input  logic        push_c,
    input  logic        set_sel,
    output logic [15:0] current,
    output logic [15:0] alarm,
    output logic [5:0]  sec,
    output logic        field_hr,
    output logic        tick
);
    localparam logic [26:0] LAST = 27'(TICK_DIV - 1);

    logic [26:0] cnt;
    logic        prev_u, prev_d, prev_c;
    logic        up, dn, act, edit_cur, edit_alm;

    function automatic logic [7:0] min_step(input logic [7:0] m, input logic inc);
        if (inc)
            return (m[3:0] == 4'd9) ? ((m[7:4] == 4'd5) ? 8'h00 : {m[7:4] + 4'd1, 4'd0})
                                    : {m[7:4], m[3:0] + 4'd1};
        return (m[3:0] == 4'd0) ? ((m[7:4] == 4'd0) ? 8'h59 : {m[7:4] - 4'd1, 4'd9})
                                : {m[7:4], m[3:0] - 4'd1};
    endfunction

    function automatic logic [7:0] hr_step(input logic [7:0] h, input logic inc);
        if (inc)
            return (h == 8'h23) ? 8'h00
                 : (h[3:0] == 4'd9) ? {h[7:4] + 4'd1, 4'd0} : {h[7:4], h[3:0] + 4'd1};
        return (h == 8'h00) ? 8'h23
             : (h[3:0] == 4'd0) ? {h[7:4] - 4'd1, 4'd9} : {h[7:4], h[3:0] - 4'd1};
    endfunction

    // Field edits never carry between minutes and hours.
    function automatic logic [15:0] edit(input logic [15:0] t, input logic hr, input logic inc);
        return hr ? {hr_step(t[15:8], inc), t[7:0]} : {t[15:8], min_step(t[7:0], inc)};
    endfunction

    // Timekeeping advance of one minute, carrying into hours.
    function automatic logic [15:0] advance(input logic [15:0] t);
        return (t[7:0] == 8'h59) ? {hr_step(t[15:8], 1'b1), 8'h00} : {t[15:8], min_step(t[7:0], 1'b1)};
    endfunction

    assign up  = push_u & ~prev_u & set_mode;
    assign dn  = push_d & ~prev_d & set_mode;
    // Coincident up and down edges cancel.
    assign act = up ^ dn;
`ifdef TIME_SET_EN
    assign edit_cur = act & set_sel;
`else
    assign edit_cur = act & set_sel & 1'b0;
`endif
    assign edit_alm = act & ~edit_cur;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt      <= '0;
            sec      <= '0;
            current  <= 16'h0000;
            alarm    <= 16'h0700;
            field_hr <= 1'b0;
            tick     <= 1'b0;
            prev_u   <= 1'b0;
            prev_d   <= 1'b0;
            prev_c   <= 1'b0;
        end else begin
            prev_u <= push_u;
            prev_d <= push_d;
            prev_c <= push_c;
            if (push_c && !prev_c)
                field_hr <= ~field_hr;
            if (edit_alm)
                alarm <= edit(alarm, field_hr, up);
            // A current-time edit restarts the second and wins over a coincident tick.
            if (edit_cur) begin
                current <= edit(current, field_hr, up);
                sec     <= '0;
                cnt     <= '0;
                tick    <= 1'b0;
            end else begin
                cnt  <= (cnt == LAST) ? '0 : cnt + 27'd1;
                tick <= (cnt == LAST - 27'd1);
                if (cnt == LAST) begin
                    sec <= (sec == 6'd59) ? 6'd0 : sec + 6'd1;
                    if (sec == 6'd59)
                        current <= advance(current);
                end
            end
        end
    end
endmodule

// File: tb/tb_alarm_time_setter.sv
// tb_alarm_time_setter: directed self-checking bench for alarm_time_setter with TICK_DIV = 4.
module tb_alarm_time_setter;
    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        set_mode = 1'b0, push_u = 1'b0, push_d = 1'b0, push_c = 1'b0, set_sel = 1'b0;
    logic [15:0] current, alarm;
    logic [5:0]  sec;
    logic        field_hr, tick;
    int          vecs = 0, errs = 0, ticks = 0;

    alarm_time_setter #(.TICK_DIV(4)) dut (
        .clk(clk), .resetn(resetn), .set_mode(set_mode), .push_u(push_u), .push_d(push_d),
        .push_c(push_c), .set_sel(set_sel), .current(current), .alarm(alarm), .sec(sec),
        .field_hr(field_hr), .tick(tick)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (tick === 1'b1) ticks++;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_u();
        push_u = 1'b1; step(2); push_u = 1'b0; step(2);
    endtask

    task automatic pulse_d();
        push_d = 1'b1; step(2); push_d = 1'b0; step(2);
    endtask

    task automatic pulse_c();
        push_c = 1'b1; step(2); push_c = 1'b0; step(2);
    endtask

    initial begin
        #2 resetn = 1'b0;
        #1;
        check("rst_current", current, 16'h0000);
        check("rst_alarm", alarm, 16'h0700);
        check("rst_sec", 16'(sec), 16'h0000);
        check("rst_field", 16'(field_hr), 16'h0000);
        check("rst_tick", 16'(tick), 16'h0000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        ticks = 0;
        step(16);
        check("run_ticks", 16'(ticks), 16'd4);
        check("run_sec", 16'(sec), 16'd4);
        check("run_current", current, 16'h0000);
        check("run_alarm", alarm, 16'h0700);

        set_mode = 1'b1;
        pulse_d(); check("min_dec_wrap", alarm, 16'h0759);
        pulse_u(); check("min_inc_wrap", alarm, 16'h0700);
        pulse_d(); check("min_dec_again", alarm, 16'h0759);
        push_u = 1'b1; step(20); push_u = 1'b0; step(2);
        check("hold_once", alarm, 16'h0700);
        push_u = 1'b1; push_d = 1'b1; step(2); push_u = 1'b0; push_d = 1'b0; step(2);
        check("cancel", alarm, 16'h0700);

        set_mode = 1'b0;
        pulse_u(); check("mode_off", alarm, 16'h0700);
        pulse_c(); check("toggle_hr", 16'(field_hr), 16'h0001);
        set_mode = 1'b1;
        for (int i = 0; i < 7; i++) pulse_d();
        check("hr_down_00", alarm, 16'h0000);
        pulse_d(); check("hr_dec_wrap", alarm, 16'h2300);
        pulse_u(); check("hr_inc_wrap", alarm, 16'h0000);
        for (int i = 0; i < 10; i++) pulse_u();
        check("hr_digit_carry", alarm, 16'h1000);
        pulse_c(); check("toggle_min", 16'(field_hr), 16'h0000);
        pulse_d(); check("min_dec_wrap2", alarm, 16'h1059);
        for (int i = 0; i < 10; i++) pulse_d();
        check("min_digit_borrow", alarm, 16'h1049);

        set_sel = 1'b1;
`ifdef TIME_SET_EN
        resetn = 1'b0; step(1); resetn = 1'b1; step(1);
        pulse_d();
        check("ts_min", current, 16'h0059);
        pulse_c();
        push_d = 1'b1; @(posedge clk); #1; push_d = 1'b0;
        check("ts_hr", current, 16'h2359);
        check("ts_sec_clr", 16'(sec), 16'h0000);
        step(232);
        check("ts_preload_sec", 16'(sec), 16'd58);
        check("ts_preload_cur", current, 16'h2359);
        step(8);
        check("rollover_cur", current, 16'h0000);
        check("rollover_sec", 16'(sec), 16'h0000);
        check("ts_alarm_kept", alarm, 16'h0700);
        set_sel = 1'b0;
        pulse_u();
`else
        pulse_u(); check("sel_ignored", alarm, 16'h1050);
        set_sel = 1'b0;
        pulse_c();
        pulse_u();
`endif
        step(5);
        @(posedge clk);
        #3 resetn = 1'b0;
        #1;
        check("mid_current", current, 16'h0000);
        check("mid_alarm", alarm, 16'h0700);
        check("mid_sec", 16'(sec), 16'h0000);
        check("mid_field", 16'(field_hr), 16'h0000);
        check("mid_tick", 16'(tick), 16'h0000);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
